// File: rtl/sp_ram_ctrl.sv
// Single-port RAM behind valid/ready request and response channels.
// Byte-enable writes, out-of-range error flagging and a sequential zero-clear after reset.
module sp_ram_ctrl #(
    parameter int W      = 32,
    parameter int D      = 16,
    parameter int ADDR_W = $clog2(D),
    parameter int CLEAR  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [W-1:0]      req_wdata,
    input  logic [W/8-1:0]    req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W-1:0]      rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);

    localparam int NB = W / 8;
    // One extra bit so a power-of-two depth does not wrap to zero in the range compare.
    localparam logic [ADDR_W:0]   DEPTH = (ADDR_W + 1)'(D);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(D - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   cnt;
    logic [W-1:0]        mem [D];

    logic                in_range;
    logic                accept;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [NB-1:0]       mem_be;
    logic [W-1:0]        mem_wdata;
    logic [W-1:0]        rd_word;

    assign in_range  = {1'b0, req_addr} < DEPTH;
    assign req_ready = (state == RUN) && (!rsp_valid || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign rd_word   = in_range ? mem[req_addr] : '0;

    // The clear engine and the request path share the single write port.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = req_addr;
        mem_be    = req_be;
        mem_wdata = req_wdata;
        if (state == INIT) begin
            mem_we    = (CLEAR != 0);
            mem_addr  = cnt;
            mem_be    = '1;
            mem_wdata = '0;
        end else if (accept && req_we && in_range) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned k = 0; k < NB; k++) begin
                if (mem_be[k]) begin
                    mem[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= INIT;
            cnt       <= '0;
            init_done <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    if (CLEAR == 0 || cnt == LAST) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (accept) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= !in_range;
                        rsp_rdata <= (!req_we && in_range) ? rd_word : '0;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Bench for sp_ram_ctrl: a 16-deep and a 12-deep instance share one stimulus stream,
// each checked every cycle against its own array-based model.
module tb_sp_ram_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_ready;

    logic [1:0]  o_ready;
    logic [1:0]  o_valid;
    logic [1:0]  o_err;
    logic [1:0]  o_done;
    logic [31:0] o_rdata [2];

    int nvec = 0;
    int nerr = 0;

    // reference model state, one slot per instance
    int          dep [2] = '{16, 12};
    logic [31:0] mm [2][16];
    logic        e_valid [2];
    logic [31:0] e_rdata [2];
    logic        e_err [2];
    logic        e_done [2];
    int          e_cyc [2];

    sp_ram_ctrl #(.W(32), .D(16), .CLEAR(1)) u16 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(o_ready[0]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(o_valid[0]), .rsp_ready(rsp_ready), .rsp_rdata(o_rdata[0]),
        .rsp_err(o_err[0]), .init_done(o_done[0])
    );

    sp_ram_ctrl #(.W(32), .D(12), .CLEAR(1)) u12 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(o_ready[1]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(o_valid[1]), .rsp_ready(rsp_ready), .rsp_rdata(o_rdata[1]),
        .rsp_err(o_err[1]), .init_done(o_done[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            e_valid[d] = 1'b0;
            e_rdata[d] = '0;
            e_err[d]   = 1'b0;
            e_done[d]  = 1'b0;
            e_cyc[d]   = 0;
        end
    endtask

    // Asynchronous reset: outputs must clear before any clock edge arrives.
    task automatic do_reset();
        rst       = 1'b0;
        req_valid = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_valid%0d", d), 32'(o_valid[d]), 32'd0);
            chk($sformatf("rst_ready%0d", d), 32'(o_ready[d]), 32'd0);
            chk($sformatf("rst_done%0d", d), 32'(o_done[d]), 32'd0);
            chk($sformatf("rst_rdata%0d", d), o_rdata[d], 32'd0);
            chk($sformatf("rst_err%0d", d), 32'(o_err[d]), 32'd0);
        end
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model at the rising edge.
    task automatic step(input logic v, input logic we, input logic [3:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input logic rr);
        logic        acc [2];
        logic        inr;
        logic [31:0] cur;
        req_valid = v;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        rsp_ready = rr;
        #4;
        for (int d = 0; d < 2; d++) begin
            acc[d] = e_done[d] && v && (!e_valid[d] || rr);
            chk($sformatf("done%0d", d), 32'(o_done[d]), 32'(e_done[d]));
            chk($sformatf("ready%0d", d), 32'(o_ready[d]), 32'(e_done[d] && (!e_valid[d] || rr)));
            chk($sformatf("valid%0d", d), 32'(o_valid[d]), 32'(e_valid[d]));
            chk($sformatf("rdata%0d", d), o_rdata[d], e_rdata[d]);
            chk($sformatf("err%0d", d), 32'(o_err[d]), 32'(e_err[d]));
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (!e_done[d]) begin
                e_cyc[d]++;
                if (e_cyc[d] == dep[d]) begin
                    e_done[d] = 1'b1;
                    for (int i = 0; i < 16; i++) mm[d][i] = '0;
                end
            end else if (acc[d]) begin
                inr = int'(addr) < dep[d];
                e_valid[d] = 1'b1;
                e_err[d]   = !inr;
                if (we) begin
                    e_rdata[d] = '0;
                    if (inr) begin
                        cur = mm[d][addr];
                        for (int k = 0; k < 4; k++)
                            if (be[k]) cur[8*k +: 8] = wdata[8*k +: 8];
                        mm[d][addr] = cur;
                    end
                end else begin
                    e_rdata[d] = inr ? mm[d][addr] : 32'd0;
                end
            end else if (rr) begin
                e_valid[d] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b1;
        model_reset();
        #2;

        // clear sequence, then read back every address
        do_reset();
        idle(16);
        chk("t1_done16", 32'(o_done[0]), 32'd1);
        for (int a = 0; a < 16; a++) step(1'b1, 1'b0, 4'(a), 32'd0, 4'd0, 1'b1);
        idle(1);

        // byte-enable merge
        step(1'b1, 1'b1, 4'd3, 32'hAABBCCDD, 4'b1111, 1'b1);
        step(1'b1, 1'b1, 4'd3, 32'h11223344, 4'b0101, 1'b1);
        step(1'b1, 1'b0, 4'd3, 32'd0, 4'd0, 1'b1);
        chk("t2_merge", o_rdata[0], 32'hAA22CC44);

        // backpressure hold, then release accepts in the same cycle
        step(1'b1, 1'b0, 4'd3, 32'd0, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'd7, 32'hDEADBEEF, 4'hF, 1'b0);
        chk("t3_hold_rdata", o_rdata[0], 32'hAA22CC44);
        chk("t3_hold_ready", 32'(o_ready[0]), 32'd0);
        step(1'b1, 1'b0, 4'd7, 32'd0, 4'd0, 1'b1);
        chk("t3_replace_valid", 32'(o_valid[0]), 32'd1);
        idle(1);

        // out of range on the 12-deep instance, in range on the 16-deep one
        step(1'b1, 1'b1, 4'd13, 32'hFFFFFFFF, 4'hF, 1'b1);
        chk("t4_werr", 32'(o_err[1]), 32'd1);
        step(1'b1, 1'b0, 4'd13, 32'd0, 4'd0, 1'b1);
        chk("t4_rerr", 32'(o_err[1]), 32'd1);
        chk("t4_rdata", o_rdata[1], 32'd0);
        chk("t4_rdata16", o_rdata[0], 32'hFFFFFFFF);
        for (int a = 0; a < 12; a++) step(1'b1, 1'b0, 4'(a), 32'd0, 4'd0, 1'b1);
        idle(1);

        // write then read the same address back to back, empty write enables
        step(1'b1, 1'b1, 4'd5, 32'h5A5A5A5A, 4'hF, 1'b1);
        step(1'b1, 1'b0, 4'd5, 32'd0, 4'd0, 1'b1);
        chk("t5_raw", o_rdata[0], 32'h5A5A5A5A);
        step(1'b1, 1'b1, 4'd5, 32'h01020304, 4'h0, 1'b1);
        step(1'b1, 1'b0, 4'd5, 32'd0, 4'd0, 1'b1);
        idle(1);
        chk("t5_be0", o_rdata[0], 32'h5A5A5A5A);

        // reset mid-clear and mid-response
        do_reset();
        idle(7);
        do_reset();
        idle(15);
        chk("t6_not_done15", 32'(o_done[0]), 32'd0);
        idle(1);
        chk("t6_done16", 32'(o_done[0]), 32'd1);
        step(1'b1, 1'b0, 4'd5, 32'd0, 4'd0, 1'b0);
        chk("t6_cleared", o_rdata[0], 32'd0);
        do_reset();
        idle(16);

        // randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom_range(0, 15)),
                 $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
